// File: rtl/leds_seq_if.sv
// leds_seq_if: control inputs and LED/tick outputs of the LED pattern generator
interface leds_seq_if #(parameter int PWM_BITS = 4);
  logic en;
  logic [1:0] mode;
  logic [PWM_BITS-1:0] bright;
  logic tick;
  logic D1, D2, D3, D4;
  modport master(output en, mode, bright, input tick, D1, D2, D3, D4);
  modport slave(input en, mode, bright, output tick, D1, D2, D3, D4);
endinterface

// File: rtl/leds_seq.sv
// leds_seq: prescaled 4-LED pattern generator (rotate/bounce/blink/count) with PWM dimming
module leds_seq #(
  parameter int DIV = 3000000,
  parameter int PWM_BITS = 4
) (
  input logic clk,
  input logic rst,
  leds_seq_if.slave bus
);
  localparam int DW = $clog2(DIV);
  localparam logic [DW-1:0] LAST = DW'(DIV - 1);
  typedef enum logic {UP, DOWN} dir_t;
  dir_t dir, dir_nx;
  logic [DW-1:0] div_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [3:0] pat, pat_nx, seed, d_nx;
  logic [1:0] mode_q;
  logic stp, gate;
  assign stp = bus.en & (div_cnt == LAST);
  assign seed = bus.mode == 2'b10 ? 4'b1111 : bus.mode == 2'b11 ? 4'b0000 : 4'b0001;
  always_ff @(posedge clk)
    if (rst) begin
      pat <= 4'b0001;
      dir <= UP;
    end else begin
      pat <= pat_nx;
      dir <= dir_nx;
    end
  // a mode change on a step tick only loads the seed; stepping resumes on the following tick
  always_comb begin
    pat_nx = pat;
    dir_nx = dir;
    if (stp) begin
      if (bus.mode != mode_q) begin
        pat_nx = seed;
        dir_nx = UP;
      end else if (mode_q == 2'b00) pat_nx = {pat[2:0], pat[3]};
      else if (mode_q == 2'b10) pat_nx = ~pat;
      else if (mode_q == 2'b11) pat_nx = pat + 4'd1;
      else if (!$onehot(pat)) begin
        pat_nx = 4'b0001;
        dir_nx = UP;
      end else if (dir == UP) begin
        pat_nx = pat << 1;
        dir_nx = pat_nx == 4'b1000 ? DOWN : UP;
      end else begin
        pat_nx = pat >> 1;
        dir_nx = pat_nx == 4'b0001 ? UP : DOWN;
      end
    end
  end
  always_comb begin
    gate = bus.bright == '0 ? 1'b0 : &bus.bright ? 1'b1 : pwm_cnt < bus.bright;
    d_nx = pat & {4{gate}};
  end
  always_ff @(posedge clk)
    if (rst) begin
      div_cnt <= '0;
      pwm_cnt <= '0;
      mode_q <= 2'b00;
      bus.tick <= 1'b0;
      {bus.D4, bus.D3, bus.D2, bus.D1} <= 4'b0000;
    end else begin
      if (bus.en) div_cnt <= div_cnt == LAST ? '0 : div_cnt + 1'b1;
      if (stp) mode_q <= bus.mode;
      pwm_cnt <= pwm_cnt + 1'b1;
      bus.tick <= stp;
      {bus.D4, bus.D3, bus.D2, bus.D1} <= d_nx;
    end
endmodule

// File: tb/tb_leds_seq.sv
// tb_leds_seq: directed stimulus with a per-cycle behavioural model of leds_seq
module tb_leds_seq;
  localparam int DIV = 4;
  localparam int PB = 4;
  logic clk = 1'b0;
  logic rst;
  leds_seq_if #(.PWM_BITS(PB)) bus();
  leds_seq #(.DIV(DIV), .PWM_BITS(PB)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  logic [3:0] d;
  assign d = {bus.D4, bus.D3, bus.D2, bus.D1};
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask
  // model: enabled-cycle count for tick timing, table position for bounce
  int ecnt, pc, bidx;
  int btab[6] = '{1, 2, 4, 8, 4, 2};
  logic [3:0] m_pat, e_d;
  logic [1:0] m_mq;
  logic e_tick, g, s;
  bit chk_on = 0;
  always @(posedge clk)
    if (rst) begin
      ecnt = 0; pc = 0; bidx = 0; m_pat = 4'd1; m_mq = 2'd0;
      e_tick = 0; e_d = 4'd0; chk_on = 1;
    end else begin
      g = bus.bright == 0 ? 1'b0 : bus.bright == 15 ? 1'b1 : (pc < int'(bus.bright));
      e_d = g ? m_pat : 4'd0;
      s = bus.en && (ecnt % DIV == DIV - 1);
      e_tick = s;
      if (bus.en) ecnt++;
      pc = (pc + 1) % 16;
      if (s) begin
        if (bus.mode != m_mq) begin
          m_mq = bus.mode;
          m_pat = bus.mode == 2 ? 4'd15 : bus.mode == 3 ? 4'd0 : 4'd1;
          bidx = 0;
        end else if (m_mq == 0) m_pat = m_pat == 8 ? 4'd1 : 4'(m_pat * 2);
        else if (m_mq == 1) begin
          bidx = (bidx + 1) % 6;
          m_pat = 4'(btab[bidx]);
        end else if (m_mq == 2) m_pat = 4'(15 - m_pat);
        else m_pat = m_pat + 4'd1;
      end
    end
  always @(negedge clk)
    if (chk_on) begin
      check("tick", bus.tick, e_tick);
      check("leds", d, e_d);
    end
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.tick !== 1'b1 && n < 20);
    check("tick_seen", bus.tick, 1);
  endtask
  task automatic next_pat(output logic [3:0] p, output int n);
    wait_tick(n);
    @(negedge clk);
    p = d;
  endtask
  logic [3:0] p, prev;
  int n, on, tcnt;
  int rot[4] = '{4, 8, 1, 2};
  int bnc[10] = '{1, 2, 4, 8, 4, 2, 1, 2, 4, 8};
  initial begin
    rst = 1; bus.en = 1; bus.mode = 2'd0; bus.bright = 4'd15;
    repeat (2) @(negedge clk);
    check("rst_leds", d, 0);
    check("rst_tick", bus.tick, 0);
    rst = 0;
    next_pat(p, n);
    check("first_tick_lat", n, DIV);
    check("rot_first", p, 2);
    for (int i = 0; i < 4; i++) begin
      next_pat(p, n);
      check("rot", p, rot[i]);
      check("tick_period", n, DIV - 1);
    end
    bus.mode = 2'd1;
    for (int i = 0; i < 10; i++) begin
      next_pat(p, n);
      check("bounce", p, bnc[i]);
    end
    rst = 1;
    @(negedge clk);
    rst = 0;
    next_pat(p, n);
    check("rst_restart_lat", n, DIV);
    check("rst_seed", p, 1);
    next_pat(p, n);
    check("rst_bounce_up", p, 2);
    bus.mode = 2'd0;
    next_pat(p, n); check("rot_load", p, 1);
    next_pat(p, n); check("rot_a", p, 2);
    next_pat(p, n); check("rot_b", p, 4);
    bus.mode = 2'd3;
    next_pat(p, n); check("cnt_load", p, 0);
    next_pat(p, n); check("cnt_1", p, 1);
    next_pat(p, n); check("cnt_2", p, 2);
    prev = p;
    for (int i = 0; i < 16; i++) begin
      next_pat(p, n);
      if (prev == 15) check("cnt_wrap", p, 0);
      check("cnt", p, 4'(prev + 1));
      prev = p;
    end
    check("cnt_full_circle", p, 2);
    bus.mode = 2'd2;
    next_pat(p, n);
    check("blink_load", p, 15);
    bus.en = 0;
    tcnt = 0;
    repeat (2) @(negedge clk) tcnt += bus.tick;
    bus.bright = 4'd4;
    repeat (2) @(negedge clk) tcnt += bus.tick;
    on = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      on += (d == 4'hf);
      tcnt += bus.tick;
    end
    check("pwm_on_4", on, 4);
    bus.bright = 4'd0;
    repeat (2) @(negedge clk) tcnt += bus.tick;
    on = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      on += (d != 4'h0);
      tcnt += bus.tick;
    end
    check("pwm_off", on, 0);
    bus.bright = 4'd15;
    repeat (2) @(negedge clk) tcnt += bus.tick;
    on = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      on += (d == 4'hf);
      tcnt += bus.tick;
    end
    check("pwm_full", on, 16);
    check("freeze_no_tick", tcnt, 0);
    bus.en = 1;
    next_pat(p, n);
    check("resume_lat", n, DIV - 1);
    check("blink_toggle", p, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
